// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared opcode nibbles and FSM state type for ram_unit
// Contents:
//   RAM_OP, ROM_OP, REG_OP      unit nibbles (opcode[15:12])
//   OP_WRITE, OP_READ, OP_FILL  operation nibbles (opcode[11:8])
//   ram_state_t                 fill controller state {IDLE, FILL}
package ram_pkg;

  localparam logic [3:0] RAM_OP   = 4'h4;
  localparam logic [3:0] ROM_OP   = 4'h3;
  localparam logic [3:0] REG_OP   = 4'h9;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_FILL  = 4'h3;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_fill_ctrl.sv
// rtl/ram_fill_ctrl.sv - FILL sequencer: walks every address once, writing a latched value
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   start              accepted FILL command (only acted on in IDLE)
//   start_value        fill value, latched on start
//   busy               high while the fill walk is in progress
//   fill_we            write strobe for the top-level write mux
//   fill_addr          address being written this cycle
//   fill_data          latched fill value
module ram_fill_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] start_value,
  output logic                  busy,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  ram_state_t            state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q, addr_next;
  logic [DATA_WIDTH-1:0] value_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      value_q <= '0;
    end else begin
      state  <= state_next;
      addr_q <= addr_next;
      if (start && state == IDLE) begin
        value_q <= start_value;
      end
    end
  end

  // The counter parks on the last address when the walk ends instead of
  // wrapping; the next accepted FILL restarts it from zero.
  always_comb begin
    state_next = state;
    addr_next  = addr_q;
    fill_we    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = FILL;
          addr_next  = '0;
        end
      end
      FILL: begin
        fill_we = 1'b1;
        if (addr_q == LAST_ADDR) begin
          state_next = IDLE;
        end else begin
          addr_next = addr_q + ADDR_WIDTH'(1);
        end
      end
    endcase
  end

  assign busy      = (state == FILL);
  assign fill_addr = addr_q;
  assign fill_data = value_q;

endmodule

// File: rtl/ram_unit.sv
// rtl/ram_unit.sv - opcode-decoded data RAM with registered reads, hardware FILL and drop flag
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   opcode[15:0]               [15:12] unit, [11:8] operation, [7:0] ROM-path address
//   operand                    address; data for RAM_OP writes and FILL
//   write_data                 data for ROM_OP / REG_OP writes
//   read_enable, write_enable  command qualifiers
//   read_data, read_valid      registered read result and one-cycle strobe
//   busy                       FILL in progress
//   cmd_dropped                one-cycle pulse for a qualified command seen while busy
// Build option: define RAM_TRACE_EN to compile in a simulation-only $display trace.
module ram_unit
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           opcode,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  cmd_dropped
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Widest of ADDR_WIDTH and the 8-bit ROM address, so the ROM byte can be
  // zero-extended or truncated with a single slice.
  localparam int EXT_W = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;

  logic [3:0]            unit;
  logic [3:0]            op;
  logic [EXT_W-1:0]      rom_ext;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic wr_cmd, rd_cmd, fill_cmd, any_cmd;
  logic wr_acc, rd_acc, fill_acc;

  logic                  fill_busy;
  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign unit    = opcode[15:12];
  assign op      = opcode[11:8];
  assign rom_ext = EXT_W'(opcode[7:0]);

  assign cmd_addr  = (unit == ROM_OP) ? rom_ext[ADDR_WIDTH-1:0] : operand[ADDR_WIDTH-1:0];
  assign cmd_wdata = (unit == RAM_OP) ? operand : write_data;

  // Unrecognised unit/operation pairs decode to nothing, so they neither act
  // nor count as dropped.
  assign wr_cmd   = write_enable && (op == OP_WRITE) &&
                    ((unit == RAM_OP) || (unit == ROM_OP) || (unit == REG_OP));
  assign rd_cmd   = read_enable && (op == OP_READ) &&
                    ((unit == RAM_OP) || (unit == REG_OP));
  assign fill_cmd = write_enable && (op == OP_FILL) && (unit == RAM_OP);
  assign any_cmd  = wr_cmd || rd_cmd || fill_cmd;

  assign wr_acc   = wr_cmd   && !fill_busy;
  assign rd_acc   = rd_cmd   && !fill_busy;
  assign fill_acc = fill_cmd && !fill_busy;

  ram_fill_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fill (
    .clk         (clk),
    .reset       (reset),
    .start       (fill_acc),
    .start_value (operand),
    .busy        (fill_busy),
    .fill_we     (fill_we),
    .fill_addr   (fill_addr),
    .fill_data   (fill_data)
  );

  // Fill and command writes are mutually exclusive: commands are only
  // accepted while the fill controller is idle. Writes are held off while
  // reset is asserted so an aborted fill leaves the rest of memory intact.
  assign mem_we    = reset && (fill_we || wr_acc);
  assign mem_waddr = fill_we ? fill_addr : cmd_addr;
  assign mem_wdata = fill_we ? fill_data : cmd_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data   <= '0;
      read_valid  <= 1'b0;
      cmd_dropped <= 1'b0;
    end else begin
      read_valid  <= rd_acc;
      cmd_dropped <= any_cmd && fill_busy;
      if (rd_acc) begin
        read_data <= mem[cmd_addr];
      end
    end
  end

  assign busy = fill_busy;

`ifdef RAM_TRACE_EN
  always @(posedge clk) begin
    if (reset) begin
      if (wr_acc)
        $display("[ram_unit] %0t write addr=0x%0h data=0x%0h", $time, cmd_addr, cmd_wdata);
      if (rd_acc)
        $display("[ram_unit] %0t read opcode=0x%04h addr=0x%0h data=0x%0h",
                 $time, opcode, cmd_addr, mem[cmd_addr]);
      if (fill_acc)
        $display("[ram_unit] %0t fill start value=0x%0h", $time, operand);
      if (fill_we && (fill_addr == ADDR_WIDTH'(DEPTH - 1)))
        $display("[ram_unit] %0t fill end", $time);
      if (any_cmd && fill_busy)
        $display("[ram_unit] %0t command dropped opcode=0x%04h", $time, opcode);
    end
  end
`endif

endmodule

// File: tb/tb_ram_unit.sv
// tb/tb_ram_unit.sv - self-checking bench for ram_unit with a behavioural reference model
module tb_ram_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16x256 instance under model checking
  logic [15:0] opcode, operand, write_data;
  logic        re, we;
  logic [15:0] rd;
  logic        rv, bsy, drp;

  ram_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(rst_n), .opcode(opcode), .operand(operand), .write_data(write_data),
    .read_enable(re), .write_enable(we), .read_data(rd), .read_valid(rv),
    .busy(bsy), .cmd_dropped(drp)
  );

  // 32x1024 instance, directed checks only
  logic [15:0] opcode2;
  logic [31:0] operand2, write_data2;
  logic        re2, we2;
  logic [31:0] rd2;
  logic        rv2, bsy2, drp2;

  ram_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut32 (
    .clk(clk), .reset(rst_n), .opcode(opcode2), .operand(operand2), .write_data(write_data2),
    .read_enable(re2), .write_enable(we2), .read_data(rd2), .read_valid(rv2),
    .busy(bsy2), .cmd_dropped(drp2)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_mem [256];
  bit          m_known [256];
  int          fill_left = 0;
  int          fill_pos  = 0;
  logic [15:0] fill_val  = '0;
  logic [15:0] e_rd = '0;
  bit          e_rd_known = 1'b1;
  bit          e_rv = 1'b0, e_busy = 1'b0, e_drop = 1'b0;
  int          mu, mo, ma;
  bit          is_w, is_r, is_f;

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        fill_left  = 0;
        e_rd       = '0;
        e_rd_known = 1'b1;
        e_rv       = 1'b0;
        e_busy     = 1'b0;
        e_drop     = 1'b0;
      end else begin
        mu   = int'(opcode[15:12]);
        mo   = int'(opcode[11:8]);
        ma   = (mu == 3) ? int'(opcode[7:0]) : int'(operand[7:0]);
        is_w = we && mo == 1 && (mu == 4 || mu == 3 || mu == 9);
        is_r = re && mo == 2 && (mu == 4 || mu == 9);
        is_f = we && mo == 3 && mu == 4;
        e_rv   = 1'b0;
        e_drop = 1'b0;
        if (fill_left > 0) begin
          m_mem[fill_pos]   = fill_val;
          m_known[fill_pos] = 1'b1;
          fill_pos++;
          fill_left--;
          e_drop = is_w || is_r || is_f;
        end else begin
          if (is_w) begin
            m_mem[ma]   = (mu == 4) ? operand : write_data;
            m_known[ma] = 1'b1;
          end
          if (is_r) begin
            e_rd       = m_mem[ma];
            e_rd_known = m_known[ma];
            e_rv       = 1'b1;
          end
          if (is_f) begin
            fill_left = 256;
            fill_pos  = 0;
            fill_val  = operand;
          end
        end
        e_busy = (fill_left > 0);
      end
    end
  end

  // every-cycle compare, away from the active edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_read_valid", 32'(rv), 32'(e_rv));
      check("model_busy", 32'(bsy), 32'(e_busy));
      check("model_cmd_dropped", 32'(drp), 32'(e_drop));
      if (e_rd_known) check("model_read_data", 32'(rd), 32'(e_rd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    opcode = '0; operand = '0; write_data = '0; re = 1'b0; we = 1'b0;
    opcode2 = '0; operand2 = '0; write_data2 = '0; re2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic issue(input logic [15:0] opc, input logic [15:0] opd,
                       input logic [15:0] wd, input logic r, input logic w);
    opcode = opc; operand = opd; write_data = wd; re = r; we = w;
    step();
    opcode = '0; operand = '0; write_data = '0; re = 1'b0; we = 1'b0;
  endtask

  task automatic issue2(input logic [15:0] opc, input logic [31:0] opd,
                        input logic [31:0] wd, input logic r, input logic w);
    opcode2 = opc; operand2 = opd; write_data2 = wd; re2 = r; we2 = w;
    step();
    opcode2 = '0; operand2 = '0; write_data2 = '0; re2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic wait_fill_done(input string name);
    int n;
    n = 0;
    while (bsy && n < 400) begin
      step();
      n++;
    end
    if (bsy) check(name, 32'(bsy), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int r, r2;
    logic [3:0] u, o;
    idle_inputs();
    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    check("reset_read_data", 32'(rd), 32'd0);
    check("reset_read_valid", 32'(rv), 32'd0);
    check("reset_busy", 32'(bsy), 32'd0);
    check("reset_cmd_dropped", 32'(drp), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // RAM write/read, one-cycle valid pulse
    issue(16'h4100, 16'h0012, 16'h0000, 1'b0, 1'b1);
    issue(16'h4200, 16'h0012, 16'h0000, 1'b1, 1'b0);
    check("ram_rd_data", 32'(rd), 32'h0012);
    check("ram_rd_valid", 32'(rv), 32'd1);
    step();
    check("ram_rd_valid_drop", 32'(rv), 32'd0);

    // ROM-path write, REG-path read
    issue(16'h3105, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
    issue(16'h9200, 16'h0005, 16'h0000, 1'b1, 1'b0);
    check("rom_wr_reg_rd", 32'(rd), 32'hBEEF);

    // FILL with a read dropped during it
    issue(16'h4300, 16'hA5A5, 16'h0000, 1'b0, 1'b1);
    check("fill_busy_rise", 32'(bsy), 32'd1);
    n = 1;
    issue(16'h4200, 16'h0005, 16'h0000, 1'b1, 1'b0);
    check("fill_drop_pulse", 32'(drp), 32'd1);
    check("fill_drop_no_valid", 32'(rv), 32'd0);
    check("fill_drop_rd_held", 32'(rd), 32'hBEEF);
    while (bsy && n < 400) begin
      n++;
      step();
    end
    check("fill_busy_cycles", 32'(n), 32'd256);
    issue(16'h4200, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("fill_after_accept", 32'(rv), 32'd1);
    check("fill_addr_00", 32'(rd), 32'hA5A5);
    issue(16'h4200, 16'h0080, 16'h0000, 1'b1, 1'b0);
    check("fill_addr_80", 32'(rd), 32'hA5A5);
    issue(16'h4200, 16'h00FF, 16'h0000, 1'b1, 1'b0);
    check("fill_addr_ff", 32'(rd), 32'hA5A5);

    // unknown operation with both enables
    issue(16'h4700, 16'h0034, 16'h7777, 1'b1, 1'b1);
    check("bad_op_valid", 32'(rv), 32'd0);
    check("bad_op_drop", 32'(drp), 32'd0);
    issue(16'h4200, 16'h0034, 16'h0000, 1'b1, 1'b0);
    check("bad_op_mem", 32'(rd), 32'hA5A5);

    // reset during a FILL
    issue(16'h4300, 16'h2222, 16'h0000, 1'b0, 1'b1);
    wait_fill_done("preload_timeout");
    issue(16'h4300, 16'h1111, 16'h0000, 1'b0, 1'b1);
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    check("abort_busy_low", 32'(bsy), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    issue(16'h4200, 16'h0009, 16'h0000, 1'b1, 1'b0);
    check("abort_addr_9", 32'(rd), 32'h1111);
    issue(16'h4200, 16'h000A, 16'h0000, 1'b1, 1'b0);
    check("abort_addr_10", 32'(rd), 32'h2222);

    // wide configuration
    issue2(16'h9100, 32'h0000_03FF, 32'hDEADBEEF, 1'b0, 1'b1);
    issue2(16'h4200, 32'h0000_03FF, 32'h0, 1'b1, 1'b0);
    check("w32_rd_3ff", rd2, 32'hDEADBEEF);
    check("w32_valid", 32'(rv2), 32'd1);
    issue2(16'h31FF, 32'h0, 32'h12345678, 1'b0, 1'b1);
    issue2(16'h9200, 32'h0000_00FF, 32'h0, 1'b1, 1'b0);
    check("w32_rom_0ff", rd2, 32'h12345678);
    issue2(16'h4200, 32'h0000_03FF, 32'h0, 1'b1, 1'b0);
    check("w32_3ff_intact", rd2, 32'hDEADBEEF);

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      r  = int'($urandom_range(0, 99));
      r2 = int'($urandom_range(0, 99));
      u  = (r < 35) ? 4'h4 : (r < 60) ? 4'h3 : (r < 85) ? 4'h9 : 4'($urandom_range(0, 15));
      o  = (r2 < 45) ? 4'h1 : (r2 < 90) ? 4'h2 : (r2 < 91) ? 4'h3 : 4'($urandom_range(0, 15));
      opcode     = {u, o, 8'($urandom)};
      operand    = 16'($urandom);
      write_data = 16'($urandom);
      re         = 1'($urandom);
      we         = 1'($urandom);
      rst_n      = ($urandom_range(0, 599) != 0);
      step();
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
    wait_fill_done("final_fill_timeout");
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_unit.md
# ram_unit

Parametrised, opcode-decoded data RAM for the processor datapath. It replaces the fixed 16×256 RAM and keeps that block's opcode encodings and write sources. New behaviour: registered reads with a valid strobe, a hardware FILL command driven by a small state machine, and a busy/drop indication. It sits on the shared opcode/operand bus beside the ROM and ALU/register blocks.

## Interface
- DATA_WIDTH, 16: word width of operand, write_data, read_data and memory words; minimum 16.
- ADDR_WIDTH, 8: address width; DEPTH = 2**ADDR_WIDTH words.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  16  bits [15:12] select the unit, bits [11:8] select the operation, bits [7:0] carry the ROM-path address.
- operand  in  DATA_WIDTH  address, and the data for RAM_OP writes and FILL.
- write_data  in  DATA_WIDTH  write data for ROM_OP and REG_OP writes.
- read_enable  in  1  qualifies read commands.
- write_enable  in  1  qualifies write and FILL commands.
- read_data  out  DATA_WIDTH  registered read result; holds its value until the next accepted read.
- read_valid  out  1  one-cycle pulse when read_data has been updated.
- busy  out  1  high while a FILL is in progress.
- cmd_dropped  out  1  one-cycle pulse when a qualified command arrives while busy.

## Operation
- Unit nibbles: RAM_OP=4'h4, ROM_OP=4'h3, REG_OP=4'h9.
- Operation nibbles: WRITE=4'h1, READ=4'h2, FILL=4'h3.
- Address:
  - ROM_OP: opcode[7:0], zero-extended or truncated to ADDR_WIDTH.
  - All other units: operand[ADDR_WIDTH-1:0].
- Writes (write_enable=1, not busy):
  - {RAM_OP,WRITE}: mem[addr] <= operand.
  - {ROM_OP,WRITE} and {REG_OP,WRITE}: mem[addr] <= write_data.
- Reads (read_enable=1, not busy):
  - {RAM_OP,READ} and {REG_OP,READ}: read_data <= mem[addr]; read_valid pulses.
  - read_data is never tristated.
- Any other opcode is ignored: no state change and no pulses.
- FILL ({RAM_OP,FILL} with write_enable=1, accepted only in IDLE): every word is set to operand.
- FSM states:
  - IDLE → FILL when a FILL is accepted; fill_addr <= 0, and operand is latched as the fill value.
  - FILL: one word written per cycle, fill_addr increments; → IDLE after the write to DEPTH-1. fill_addr never wraps.
- While busy, every qualified read, write or FILL is discarded and cmd_dropped pulses.
- Reset values: read_data=0, read_valid=0, busy=0, cmd_dropped=0, FSM=IDLE, fill_addr=0. Memory contents are not reset.
- Reset asserted mid-FILL aborts the fill: words already written keep the fill value, and the remaining words are unchanged.

## Timing
- Write: the memory updates at the edge that samples the command. A read issued in the next cycle to the same address returns the new data.
- Read: command sampled at edge N → read_data and read_valid valid after edge N. Latency is 1 cycle.
- Back-to-back reads give one valid pulse per cycle.
- FILL accepted at edge N:
  - Edges N+1 … N+DEPTH write addresses 0 … DEPTH-1.
  - busy is high from after edge N until after edge N+DEPTH, i.e. exactly DEPTH cycles.
  - A command in the cycle right after busy falls is accepted.
- cmd_dropped is registered: it is high for the one cycle after the edge that sampled the dropped command.
- read_enable and write_enable high together: each is decoded independently against opcode. Because a single opcode cannot encode both a READ and a WRITE, at most one of them takes effect.

## Configuration
- RAM_TRACE_EN defined: the simulation-only $display trace is compiled in. Each accepted write prints time, addr and data. Each accepted read prints time, opcode, addr and data. FILL start/end and every dropped command are also printed.
- RAM_TRACE_EN undefined: no $display statements. Functional behaviour is identical either way.

## Structure
- Package ram_pkg holds:
  - the unit nibbles RAM_OP, ROM_OP and REG_OP;
  - the operation nibbles OP_WRITE, OP_READ and OP_FILL;
  - the FSM state enum ram_state_t {IDLE, FILL}.
- Sub-module ram_fill_ctrl holds the FSM, fill_addr counter, latched fill value and busy. It exports the write strobe, address and data for the top-level write mux.
- The top level holds the address mux, the write mux (command vs. fill), the memory array and the registered read port.

## Test plan
- {RAM_OP,WRITE}, operand=0x0012 → then {RAM_OP,READ}, operand=0x0012 → read_data=0x0012, read_valid high for exactly one cycle, one edge after the read.
- {ROM_OP,WRITE} with opcode low byte=0x05 and write_data=0xBEEF → then {REG_OP,READ}, operand=0x0005 → read_data=0xBEEF.
- {RAM_OP,FILL}, operand=0xA5A5, DEPTH=256 → busy high for 256 cycles. A read issued during the fill pulses cmd_dropped and leaves read_data unchanged. After the fill, reads of addresses 0x00, 0x80 and 0xFF return 0xA5A5.
- reset pulsed low at fill cycle 10 of a FILL with 0x1111 over a memory preloaded with 0x2222 → busy=0 immediately. Address 9 reads 0x1111; address 10 reads 0x2222.
- Opcode 0x4700 with both enables high → memory unchanged, read_valid=0, cmd_dropped=0.
- DATA_WIDTH=32, ADDR_WIDTH=10 → write 0xDEADBEEF to address 0x3FF and read it back correctly. {ROM_OP,WRITE} with opcode low byte=0xFF targets address 0x0FF.
